ifetch_unit: RTL
================

// Module: ifetch_unit
// PURPOSE
//   Instruction fetch stage. Feeds the pipeline control unit's `instruction` input.
//   - Owns the fetch PC and issues requests to instruction memory over a req/ack handshake.
//   - Buffers returned words in a small prefetch FIFO.
//   - Applies the NPCop/PCwr redirect decided by control: sequential, branch target, IRQ vector.
//   - Presents 32'd0 (bubble) when nothing is fetched; control treats 0 as a NOP.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch address after reset
//   IRQ_VECTOR  32'h0000_0018  fetch address for NPCop=2'b10
//   FIFO_DEPTH  2              prefetch entries; power of two, >=2
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   reset, asynchronous, active-low
//   PCwr         in   1   1 = pipeline advances this cycle (pop/redirect allowed); 0 = hold
//   NPCop        in   2   00 seq, 01 branch (br_target), 10 IRQ_VECTOR, 11 treated as 00
//   br_target    in   32  branch target computed in EX
//   imem_req     out  1   memory request valid
//   imem_addr    out  32  word address of request (= fetch PC)
//   imem_ack     in   1   memory response valid; completes the request
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   instruction  out  32  FIFO head word; 32'd0 when FIFO empty
//   fetch_valid  out  1   FIFO non-empty
//   if_pc        out  32  address of head word; 0 when empty
//   if_pc4       out  32  if_pc+4 mod 2^32 (link value for BL/IRQ)
// BEHAVIOUR
//   Reset (async, rst=0): fpc=RESET_PC, FIFO empty, imem_req=0, state=RUN, instruction=0,
//     fetch_valid=0, if_pc=0, if_pc4=4. Any outstanding memory access is abandoned; memory is
//     reset by the same rst.
//   FSM states RUN, WAIT, DRAIN:
//     RUN:   if occupancy < FIFO_DEPTH -> imem_req=1, imem_addr=fpc, go WAIT.
//     WAIT:  hold imem_req/imem_addr stable until imem_ack.
//            On ack: push {fpc, imem_rdata}, fpc<=fpc+4, go RUN.
//     DRAIN: a redirect arrived while a request was outstanding. Hold req until ack,
//            discard the returned data, then go RUN at the new fpc.
//   Request issue rule: occupancy + outstanding <= FIFO_DEPTH, so a push never overflows.
//   Pop: PCwr=1 and NPCop in {00,11} and FIFO non-empty -> head removed at clk edge.
//     Control samples `instruction` on the same edge.
//   Redirect: PCwr=1, NPCop=01 -> fpc<=br_target; NPCop=10 -> fpc<=IRQ_VECTOR.
//     - FIFO flushed the same edge; no pop.
//     - If in WAIT without ack -> DRAIN.
//     - If ack arrives the same cycle -> data dropped, go RUN.
//     - Redirect while in DRAIN -> fpc updated, stay DRAIN.
//   PCwr=0: no pop, no redirect; fetching continues until the FIFO is full, then imem_req=0 in RUN.
//   Pop and push in the same cycle are both performed; occupancy is unchanged.
//   Arithmetic: fpc and if_pc4 wrap mod 2^32. Low 2 address bits are passed through unchecked.
//   Ack while imem_req=0 is ignored.
//   Latency: minimum 2 cycles from redirect edge to fetch_valid (1-cycle-ack memory).
// TESTING
//   1. Reset release, 1-cycle ack, PCwr=1, NPCop=00 -> if_pc 0x0,0x4,0x8 in order;
//      instruction=0 until first ack.
//   2. Ack latency 3 cycles -> fetch_valid=0, instruction=0 during gaps;
//      each address requested exactly once.
//   3. Req to 0x0C outstanding, NPCop=01, br_target=0x100 -> 0x0C data discarded;
//      next imem_addr=0x100; first valid if_pc=0x100.
//   4. NPCop=10 -> next imem_addr=0x18; head if_pc=0x18, if_pc4=0x1C.
//   5. PCwr=0 for 6 cycles -> occupancy reaches 2, imem_req=0, head held;
//      PCwr=1 -> words popped in order, none lost or duplicated.
//   6. br_target=0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x0;
//      rst=0 mid-WAIT -> all outputs take reset values immediately (no clock).

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage.
//
// Owns the fetch PC (fpc), requests instruction words from memory over a
// req/ack handshake, buffers returned words in a small prefetch FIFO and
// presents the head word to the pipeline control unit. Control steers the
// fetch PC through PCwr/NPCop: sequential, branch target or IRQ vector.
// An empty FIFO presents a 32'd0 bubble, which control decodes as a NOP.
//
// Parameters
//   RESET_PC    fetch address after reset
//   IRQ_VECTOR  fetch address for NPCop = 2'b10
//   FIFO_DEPTH  prefetch entries; power of two, >= 2
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   PCwr         in   1   pipeline advances this cycle (pop/redirect allowed)
//   NPCop        in   2   00 seq, 01 branch, 10 IRQ vector, 11 as 00
//   br_target    in   32  branch target from EX
//   imem_req     out  1   memory request valid (registered)
//   imem_addr    out  32  request word address (registered)
//   imem_ack     in   1   memory response valid, completes the request
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   instruction  out  32  FIFO head word, 0 when empty
//   fetch_valid  out  1   FIFO non-empty
//   if_pc        out  32  address of head word, 0 when empty
//   if_pc4       out  32  if_pc + 4 (wraps)

module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h0000_0018,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCwr,
    input  logic [1:0]  NPCop,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        fetch_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e          state;
    logic [31:0]     fpc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fifo_pc   [FIFO_DEPTH];
    logic [31:0]     fifo_data [FIFO_DEPTH];

    logic            seq_op;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            push;
    logic            pop;
    logic            can_issue;

    // Control decode. NPCop 11 behaves as sequential.
    always_comb begin
        seq_op      = (NPCop == 2'b00) || (NPCop == 2'b11);
        redirect    = PCwr && !seq_op;
        redirect_pc = (NPCop == 2'b10) ? IRQ_VECTOR : br_target;
        pop         = PCwr && seq_op && (count != '0);
        // Only an undisturbed WAIT delivers data; a same-cycle redirect drops it.
        push        = (state == StWait) && imem_ack && !redirect;
        // Nothing is outstanding in RUN, so count < depth guarantees a free slot.
        can_issue   = (count < DepthC) && !redirect;
    end

    // Fetch FSM, fetch PC, request outputs and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StRun;
            fpc       <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            // FIFO pointers: a redirect flushes, otherwise push and pop may coincide.
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end

            case (state)
                StRun: begin
                    if (redirect) begin
                        fpc <= redirect_pc;
                    end else if (can_issue) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fpc;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (redirect) begin
                        fpc <= redirect_pc;
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= StRun;
                        end else begin
                            // Request must still complete; its data will be discarded.
                            state <= StDrain;
                        end
                    end else if (imem_ack) begin
                        fpc      <= fpc + 32'd4;
                        imem_req <= 1'b0;
                        state    <= StRun;
                    end
                end
                StDrain: begin
                    if (redirect) begin
                        fpc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= StRun;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= StRun;
                end
            endcase
        end
    end

    // FIFO storage; contents are only observed through count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= imem_addr;
            fifo_data[wr_ptr] <= imem_rdata;
        end
    end

    always_comb begin
        fetch_valid = (count != '0);
        instruction = fetch_valid ? fifo_data[rd_ptr] : 32'd0;
        if_pc       = fetch_valid ? fifo_pc[rd_ptr] : 32'd0;
        if_pc4      = if_pc + 32'd4;
    end

endmodule
